muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer; 32 radix-2 iterations per op.
//  Each iteration's 32-bit add/subtract runs on the shared ALU through alu_op/alu_a/alu_b/alu_out.
//  Sits beside the execute stage; the core stalls while busy=1.
// PARAMETERS
//  XLEN        32  operand/result width (only 32 supported)
//  ITERS       32  iteration count in RUN (= XLEN)
// PORTS
//  clk       in   1     rising-edge clock
//  rst_n     in   1     synchronous, active-low reset
//  start     in   1     request; accepted when state is IDLE or DONE
//  funct3    in   3     0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//  rs1       in   32    operand A (dividend / multiplicand)
//  rs2       in   32    operand B (divisor / multiplier)
//  busy      out  1     high in PREP, RUN and FIX
//  done      out  1     one-cycle pulse; result valid
//  result    out  32    final value, held until the next accepted start
//  alu_op    out  4     ALU opcode: ADD=4'd0, SUB=4'd8
//  alu_a     out  32    ALU operand1
//  alu_b     out  32    ALU operand2
//  alu_out   in   32    combinational ALU result, same cycle
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; busy=0, done=0, result=0.
//   - alu_op=ADD, alu_a=0, alu_b=0; all internal registers cleared.
//  FSM: IDLE -start-> PREP -> RUN(x32) -> FIX -> DONE; DONE -start-> PREP, else DONE -> IDLE.
//  Operand latching:
//   - funct3/rs1/rs2 are latched on the accepting edge; later changes are ignored.
//   - start while busy=1 is ignored (not queued).
//  PREP: signed ops take |rs1|, |rs2| and record the sign of the final result.
//  RUN, multiply (shift-add):
//   - If multiplier LSB=1: alu_op=ADD, alu_a=acc_hi, alu_b=multiplicand.
//   - carry = (alu_out < alu_a) unsigned; {carry, alu_out, acc_lo} shifts right 1.
//  RUN, divide (restoring):
//   - Shift {rem, quo} left 1.
//   - Trial: alu_op=SUB, alu_a=rem[31:0], alu_b=divisor.
//   - Borrow-free (rem bit32=1 or rem[31:0] >= divisor): rem<=alu_out, quo LSB=1.
//  RUN, idle ALU: when no ALU op is needed, drive alu_op=ADD, alu_a=alu_b=0.
//  FIX:
//   - Negate the product/quotient if the recorded sign is negative.
//   - Remainder takes the dividend's sign.
//   - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
//  Special results (RISC-V; applied in FIX):
//   - Divide by zero: quotient=32'hFFFFFFFF, remainder=rs1.
//   - Signed overflow (rs1=32'h80000000, rs2=-1): quotient=32'h80000000, remainder=0.
//  Latency: start accepted at edge N; done=1 in cycle N+35 (PREP 1 + RUN 32 + FIX 1 + DONE).
//  Back-to-back: start while in DONE begins a new op; done drops the next cycle.
//  Reset mid-operation: aborts immediately, no done pulse, result=0.
// CONFIGURATION
//  MULDIV_FAST_SPECIAL_EN
//   - Defined: PREP detects divide-by-zero, signed overflow, or a zero multiply operand.
//     It loads the special result and goes straight to DONE; done at N+2.
//   - Undefined: every op takes the full 35-cycle path.
//   - Results are bit-identical in both builds.
// STRUCTURE
//  Package muldiv_pkg:
//   - funct3 localparams, FSM state encoding.
//   - ALU opcode constants ALU_ADD=4'd0 and ALU_SUB=4'd8, shared with the ALU.
//  Sub-module muldiv_sign_fix: combinational abs/negate and result select for PREP/FIX.
//  Iteration counter: 5-bit, counts ITERS-1 down to 0.
// TESTING
//  - MUL rs1=7, rs2=-3 -> result=32'hFFFFFFEB, done at N+35, busy high N+1..N+34.
//  - MULHU rs1=rs2=32'hFFFFFFFF -> 32'hFFFFFFFE; MULH same operands -> 32'h00000000.
//  - DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIVU 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5.
//    DIV 32'h80000000/-1 -> 32'h80000000; REM same operands -> 0.
//    Latency: N+2 with MULDIV_FAST_SPECIAL_EN, N+35 without.
//  - start pulses during RUN are ignored; a new start in the DONE cycle is accepted.
//    Check: next done at +35, result unchanged until then.
//  - rst_n=0 at iteration 10 -> busy=0, result=0, no done.
//    A new op started after reset returns the correct value.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, funct3 codes, ALU opcodes and FSM encoding for muldiv_seq.
package muldiv_pkg;
   localparam int XLEN = 32;
   localparam int ITERS = 32;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd8;
   localparam logic [2:0] F3_MUL = 3'd0;
   localparam logic [2:0] F3_MULH = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU = 3'd3;
   localparam logic [2:0] F3_DIV = 3'd4;
   localparam logic [2:0] F3_DIVU = 3'd5;
   localparam logic [2:0] F3_REM = 3'd6;
   localparam logic [2:0] F3_REMU = 3'd7;
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake and shared-ALU hookup between core and muldiv_seq.
interface muldiv_if;
   import muldiv_pkg::*;
   logic start;
   logic [2:0] funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic busy;
   logic done;
   logic [XLEN-1:0] result;
   logic [3:0] alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_out;
   modport master (
      output start, funct3, rs1, rs2, alu_out,
      input busy, done, result, alu_op, alu_a, alu_b
   );
   modport slave (
      input start, funct3, rs1, rs2, alu_out,
      output busy, done, result, alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitudes for PREP and sign-corrected/special result select for FIX.
module muldiv_sign_fix
   import muldiv_pkg::*;
(
   input logic [2:0] f3,
   input logic [XLEN-1:0] a,
   input logic [XLEN-1:0] b,
   input logic [XLEN-1:0] hi,
   input logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] abs_a,
   output logic [XLEN-1:0] abs_b,
   output logic [XLEN-1:0] res,
   output logic special
);
   logic mul, sa, sb, neg_a, neg_b, neg_q, div0, ovf, zmul;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo, rem, normal, spec_res;
   always_comb begin
      mul = !f3[2];
      sa = mul ? f3 != F3_MULHU : !f3[0];
      sb = mul ? (f3 == F3_MUL || f3 == F3_MULH) : !f3[0];
      neg_a = sa && a[XLEN-1];
      neg_b = sb && b[XLEN-1];
      abs_a = neg_a ? -a : a;
      abs_b = neg_b ? -b : b;
      neg_q = neg_a ^ neg_b;
      prod = neg_q ? -{hi, lo} : {hi, lo};
      quo = neg_q ? -lo : lo;
      rem = neg_a ? -hi : hi;
      div0 = !mul && b == '0;
      ovf = !mul && !f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
      zmul = mul && (a == '0 || b == '0);
      special = div0 || ovf || zmul;
      // overflow quotient equals the dividend (most negative value)
      spec_res = zmul ? '0 : div0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
      normal = mul ? (f3 == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : (f3[1] ? rem : quo);
      res = special ? spec_res : normal;
   end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide using the shared ALU, one radix-2 step per cycle.
// Define MULDIV_FAST_SPECIAL_EN to finish zero-operand, divide-by-zero and overflow ops from PREP.
module muldiv_seq
   import muldiv_pkg::*;
(
   input logic clk,
   input logic rst_n,
   muldiv_if.slave bus
);
`ifdef MULDIV_FAST_SPECIAL_EN
   localparam logic fast_special = 1'b1;
`else
   localparam logic fast_special = 1'b0;
`endif
   state_t state, state_nx;
   logic [2:0] f3;
   logic [XLEN-1:0] a, b, hi, lo, d, abs_a, abs_b, res, result;
   logic [4:0] cnt;
   logic accept, mul, special, ok, carry;
   logic [XLEN:0] rem_s;
   assign accept = bus.start && (state == S_IDLE || state == S_DONE);
   assign mul = !f3[2];
   assign rem_s = {hi, lo[XLEN-1]};
   assign ok = rem_s >= {1'b0, d};
   assign carry = bus.alu_out < hi;
   assign bus.result = result;
   muldiv_sign_fix u_fix (
      .f3(f3),
      .a(a),
      .b(b),
      .hi(hi),
      .lo(lo),
      .abs_a(abs_a),
      .abs_b(abs_b),
      .res(res),
      .special(special)
   );
   always_ff @(posedge clk) state <= !rst_n ? S_IDLE : state_nx;
   always_comb begin
      state_nx = state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      bus.alu_op = ALU_ADD;
      bus.alu_a = '0;
      bus.alu_b = '0;
      case (state)
         S_IDLE: state_nx = bus.start ? S_PREP : S_IDLE;
         S_PREP: begin
            bus.busy = 1'b1;
            state_nx = (fast_special && special) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            bus.busy = 1'b1;
            bus.alu_op = mul ? ALU_ADD : ALU_SUB;
            bus.alu_a = mul ? (lo[0] ? hi : '0) : rem_s[XLEN-1:0];
            bus.alu_b = mul ? (lo[0] ? d : '0) : d;
            state_nx = cnt == 5'd0 ? S_FIX : S_RUN;
         end
         S_FIX: begin
            bus.busy = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_nx = bus.start ? S_PREP : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end
   // hi/lo hold {acc_hi, multiplier} for multiply and {rem, quo} for divide
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f3 <= '0;
         a <= '0;
         b <= '0;
         hi <= '0;
         lo <= '0;
         d <= '0;
         cnt <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            f3 <= bus.funct3;
            a <= bus.rs1;
            b <= bus.rs2;
         end
         if (state == S_PREP) begin
            hi <= '0;
            lo <= mul ? abs_b : abs_a;
            d <= mul ? abs_a : abs_b;
            cnt <= 5'(ITERS - 1);
            if (fast_special && special) result <= res;
         end
         if (state == S_RUN) begin
            cnt <= cnt - 5'd1;
            if (mul) begin
               hi <= lo[0] ? {carry, bus.alu_out[XLEN-1:1]} : {1'b0, hi[XLEN-1:1]};
               lo <= {lo[0] ? bus.alu_out[0] : hi[0], lo[XLEN-1:1]};
            end else begin
               hi <= ok ? bus.alu_out : rem_s[XLEN-1:0];
               lo <= {lo[XLEN-2:0], ok};
            end
         end
         if (state == S_FIX) result <= res;
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table, random ops against a reference model, and handshake corner cases.
module tb_muldiv_seq;
   import muldiv_pkg::*;
`ifdef MULDIV_FAST_SPECIAL_EN
   localparam bit fast = 1'b1;
`else
   localparam bit fast = 1'b0;
`endif
   typedef struct {
      logic [2:0] f;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prev_res = '0;
   vec_t tbl[17];
   muldiv_if bus();
   muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.alu_out = bus.alu_op == ALU_SUB ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xs, xu, ys, yu, p;
      logic signed [31:0] sx, sy;
      logic [31:0] r;
      logic z, ovf;
      xs = {{32{x[31]}}, x};
      xu = {32'd0, x};
      ys = {{32{y[31]}}, y};
      yu = {32'd0, y};
      sx = x;
      sy = y;
      z = y == 32'd0;
      ovf = x == 32'h80000000 && y == 32'hFFFFFFFF;
      p = '0;
      r = '0;
      case (f)
         F3_MUL: begin p = xs * ys; r = p[31:0]; end
         F3_MULH: begin p = xs * ys; r = p[63:32]; end
         F3_MULHSU: begin p = xs * yu; r = p[63:32]; end
         F3_MULHU: begin p = xu * yu; r = p[63:32]; end
         F3_DIV: if (z) r = '1; else if (ovf) r = x; else r = 32'(sx / sy);
         F3_DIVU: if (z) r = '1; else r = x / y;
         F3_REM: if (z) r = x; else if (ovf) r = '0; else r = 32'(sx % sy);
         default: if (z) r = x; else r = x % y;
      endcase
      return r;
   endfunction

   function automatic int lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      bit sp;
      sp = f[2] ? (y == 32'd0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))
                : (x == 32'd0 || y == 32'd0);
      return (fast && sp) ? 2 : 35;
   endfunction

   // drive at a negedge; returns one negedge later with inputs scrambled
   task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
      bus.start = 1'b1;
      bus.funct3 = f;
      bus.rs1 = x;
      bus.rs2 = y;
      exp_q.push_back(exp);
      @(negedge clk);
      bus.start = 1'b0;
      bus.funct3 = 3'($urandom);
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
   endtask

   task automatic wait_done(input string name, input int n0, input int want_lat);
      int n = n0;
      bit hold_ok = 1'b1;
      logic [31:0] want;
      while (!bus.done && n < 100) begin
         hold_ok &= bus.busy === 1'b1 && bus.result === prev_res;
         @(negedge clk);
         n++;
      end
      check({name, " busy/hold"}, 32'(hold_ok), 32'd1);
      check({name, " latency"}, n, want_lat);
      check({name, " busy@done"}, 32'(bus.busy), 32'd0);
      want = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
      check({name, " result"}, bus.result, want);
      prev_res = want;
   endtask

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
      @(negedge clk);
      launch(f, x, y, exp);
      wait_done(name, 1, lat(f, x, y));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      tbl = '{
         '{F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB},
         '{F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
         '{F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
         '{F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF},
         '{F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000},
         '{F3_MUL, 32'd0, 32'd12345, 32'd0},
         '{F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD},
         '{F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF},
         '{F3_DIVU, 32'd100, 32'd7, 32'd14},
         '{F3_REMU, 32'd100, 32'd7, 32'd2},
         '{F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD},
         '{F3_REM, 32'd7, 32'hFFFFFFFE, 32'd1},
         '{F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF},
         '{F3_REM, 32'd5, 32'd0, 32'd5},
         '{F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
         '{F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0},
         '{F3_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF}
      };
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.funct3 = '0;
      bus.rs1 = '0;
      bus.rs2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      check("reset alu_a", bus.alu_a, 32'd0);
      check("reset alu_b", bus.alu_b, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++)
         run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].exp);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] f;
         logic [31:0] x, y;
         f = 3'($urandom_range(0, 7));
         x = $urandom;
         y = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_op($sformatf("rnd%0d f3=%0d", i, f), f, x, y, model(f, x, y));
      end
      // multiplier LSB decides between idle ALU and acc_hi + multiplicand
      @(negedge clk);
      launch(F3_MUL, 32'd5, 32'd2, 32'd10);
      @(negedge clk);
      check("mul idle alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      check("mul idle alu_b", bus.alu_b, 32'd0);
      @(negedge clk);
      check("mul add alu_b", bus.alu_b, 32'd5);
      wait_done("mul alu", 3, 35);
      // start during RUN is dropped; start in DONE is accepted back-to-back
      @(negedge clk);
      launch(F3_DIVU, 32'd100, 32'd7, 32'd14);
      repeat (4) @(negedge clk);
      check("div alu_op", 32'(bus.alu_op), 32'(ALU_SUB));
      bus.start = 1'b1;
      bus.funct3 = F3_MUL;
      bus.rs1 = 32'd3;
      bus.rs2 = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ignored start", 6, 35);
      launch(F3_MUL, 32'd6, 32'd7, 32'd42);
      wait_done("back-to-back", 1, 35);
      // reset at iteration 10 aborts without a done pulse
      @(negedge clk);
      launch(F3_DIV, 32'd1000, 32'd3, 32'd333);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort result", bus.result, 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      prev_res = '0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= bus.done;
      end
      check("no done after abort", 32'(seen), 32'd0);
      run_op("post-reset", F3_REM, 32'd1000, 32'd3, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
